// File: rtl/if_fetch_stage_pkg.sv
// Shared IF-stage definitions: fetch FSM states, reset PC, NOP encoding and rs/rt field positions.
// Pure declarations, no logic; imported by the fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/if_fetch_stage_ifid.sv
// IF/ID pipeline register with write enable and flush; 1-cycle latency.
// No backpressure of its own: flush beats write enable, we=0 holds the contents.
module ifid_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] instr_d,
  input  logic [DATA_WIDTH-1:0] pc4_d,
  input  logic                  valid_d,
  output logic [DATA_WIDTH-1:0] instr_q,
  output logic [DATA_WIDTH-1:0] pc4_q,
  output logic                  valid_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= DATA_WIDTH'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= DATA_WIDTH'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (we) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: PC, imem req/ready handshake, redirects, IF/ID register; IF/ID valid 1 cycle after ready.
// Backpressure: PC_En/IFID_ctrl stall parks a returned word in buf_q (HOLD, no request); redirects override stalls.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PC_En,
  input  logic                  IFID_ctrl,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump_taken,
  input  logic [DATA_WIDTH-1:0] jump_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] IF_ID_instr,
  output logic [DATA_WIDTH-1:0] IF_ID_pc4,
  output logic                  IF_ID_valid,
  output logic [4:0]            IF_ID_rs,
  output logic [4:0]            IF_ID_rt,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, buf_q, buf_d, redir_q, redir_d;
  logic [DATA_WIDTH-1:0] pc_plus4, target;
  logic                  advance, redirect;
  logic                  ifid_we, ifid_flush, ifid_valid_d;
  logic [DATA_WIDTH-1:0] ifid_instr_d, ifid_pc4_d;

  assign advance  = PC_En & IFID_ctrl;
  assign redirect = branch_taken | jump_taken;
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign imem_req  = rst_n & (state_q != HOLD);
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    redir_d      = redir_q;
    ifid_flush   = redirect;
    ifid_we      = IFID_ctrl;
    ifid_instr_d = DATA_WIDTH'(NOP);
    ifid_pc4_d   = '0;
    ifid_valid_d = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d = target;
          end else if (advance) begin
            ifid_we      = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          redir_d = target;
          state_d = KILL;
        end
      end
      KILL: begin
        if (redirect) redir_d = target;
        if (imem_ready) begin
          pc_d    = redirect ? target : redir_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (advance) begin
          ifid_we      = 1'b1;
          ifid_instr_d = buf_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      redir_q     <= '0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
      if (!PC_En && (stall_count != '1)) stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  ifid_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (ifid_we),
    .flush   (ifid_flush),
    .instr_d (ifid_instr_d),
    .pc4_d   (ifid_pc4_d),
    .valid_d (ifid_valid_d),
    .instr_q (IF_ID_instr),
    .pc4_q   (IF_ID_pc4),
    .valid_q (IF_ID_valid)
  );

  assign IF_ID_rs = IF_ID_instr[RS_MSB:RS_LSB];
  assign IF_ID_rt = IF_ID_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, zero-wait fetch, stall/HOLD, branch, KILL, HOLD redirect,
// PC wrap and stall counter saturation with asynchronous reset mid-stall.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_En, IFID_ctrl;
  logic        branch_taken, jump_taken;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_instr, IF_ID_pc4;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_rs, IF_ID_rt;
  logic [15:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_En(PC_En), .IFID_ctrl(IFID_ctrl),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PC_En = 1'b1; IFID_ctrl = 1'b1;
    branch_taken = 1'b0; jump_taken = 1'b0; branch_target = '0; jump_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    #1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got %h exp 0", imem_req); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL rst_valid got %h exp 0", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0) $display("FAIL rst_pc4 got %h exp 0", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'h0) $display("FAIL rst_stall got %h exp 0", stall_count); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL rel_req got %h exp 1", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0000) $display("FAIL rel_addr got %h exp 00400000", imem_addr); else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    imem_ready = 1'b1;
    imem_rdata = 32'h2000_0001; tick();
    total_cnt++; if (imem_addr !== 32'h0040_0004) $display("FAIL zw_addr1 got %h exp 00400004", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_0004) $display("FAIL zw_pc4_1 got %h exp 00400004", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL zw_valid1 got %h exp 1", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h2000_0001) $display("FAIL zw_instr1 got %h exp 20000001", IF_ID_instr); else pass_cnt++;
    imem_rdata = 32'h2000_0002; tick();
    total_cnt++; if (imem_addr !== 32'h0040_0008) $display("FAIL zw_addr2 got %h exp 00400008", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h2000_0002) $display("FAIL zw_instr2 got %h exp 20000002", IF_ID_instr); else pass_cnt++;
    imem_rdata = 32'h2000_0003; tick();
    total_cnt++; if (imem_addr !== 32'h0040_000C) $display("FAIL zw_addr3 got %h exp 0040000c", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_000C) $display("FAIL zw_pc4_3 got %h exp 0040000c", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd0) $display("FAIL zw_stall got %0d exp 0", stall_count); else pass_cnt++;
  endtask

  task automatic test_stall_hold();
    PC_En = 1'b0; IFID_ctrl = 1'b0;
    imem_rdata = 32'h8C82_0000; tick();
    imem_rdata = 32'hBAD0_0000; tick();
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL hold_req got %h exp 0", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_000C) $display("FAIL hold_addr got %h exp 0040000c", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h2000_0003) $display("FAIL hold_instr got %h exp 20000003", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL hold_valid got %h exp 1", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd2) $display("FAIL hold_stall got %0d exp 2", stall_count); else pass_cnt++;
    PC_En = 1'b1; IFID_ctrl = 1'b1; tick();
    total_cnt++; if (IF_ID_instr !== 32'h8C82_0000) $display("FAIL rel_instr got %h exp 8c820000", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_0010) $display("FAIL rel_pc4 got %h exp 00400010", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0010) $display("FAIL rel_addr2 got %h exp 00400010", imem_addr); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL rel_req2 got %h exp 1", imem_req); else pass_cnt++;
    total_cnt++; if (IF_ID_rs !== 5'd4) $display("FAIL rel_rs got %0d exp 4", IF_ID_rs); else pass_cnt++;
    total_cnt++; if (IF_ID_rt !== 5'd2) $display("FAIL rel_rt got %0d exp 2", IF_ID_rt); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd2) $display("FAIL rel_stall got %0d exp 2", stall_count); else pass_cnt++;
  endtask

  task automatic test_branch();
    // Both redirects at once: the branch wins.
    imem_rdata = 32'h1111_1111;
    branch_taken = 1'b1; branch_target = 32'h0040_0100;
    jump_taken = 1'b1; jump_target = 32'h0040_0500;
    tick();
    branch_taken = 1'b0; jump_taken = 1'b0;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL br_valid got %h exp 0", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h0) $display("FAIL br_instr got %h exp 0", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0100) $display("FAIL br_addr got %h exp 00400100", imem_addr); else pass_cnt++;
    imem_rdata = 32'h1234_5678; tick();
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_0104) $display("FAIL br_pc4 got %h exp 00400104", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b1) $display("FAIL br_valid2 got %h exp 1", IF_ID_valid); else pass_cnt++;
  endtask

  task automatic test_kill();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    jump_taken = 1'b1; jump_target = 32'h0040_0200; tick();
    jump_taken = 1'b0;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL kill_flush got %h exp 0", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0104) $display("FAIL kill_addr got %h exp 00400104", imem_addr); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL kill_req got %h exp 1", imem_req); else pass_cnt++;
    tick();
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL kill_bub got %h exp 0", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0104) $display("FAIL kill_addr2 got %h exp 00400104", imem_addr); else pass_cnt++;
    imem_ready = 1'b1; tick();
    total_cnt++; if (imem_addr !== 32'h0040_0200) $display("FAIL kill_tgt got %h exp 00400200", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h0) $display("FAIL kill_drop got %h exp 0", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL kill_bub2 got %h exp 0", IF_ID_valid); else pass_cnt++;
    imem_rdata = 32'h2222_2222; tick();
    total_cnt++; if (IF_ID_instr !== 32'h2222_2222) $display("FAIL kill_next got %h exp 22222222", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_0204) $display("FAIL kill_pc4 got %h exp 00400204", IF_ID_pc4); else pass_cnt++;
  endtask

  task automatic test_hold_redirect();
    PC_En = 1'b0; IFID_ctrl = 1'b0;
    imem_rdata = 32'h3333_3333; tick();
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL hr_req got %h exp 0", imem_req); else pass_cnt++;
    branch_taken = 1'b1; branch_target = 32'h0040_0300; tick();
    branch_taken = 1'b0;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL hr_flush got %h exp 0", IF_ID_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0300) $display("FAIL hr_addr got %h exp 00400300", imem_addr); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL hr_req2 got %h exp 1", imem_req); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd4) $display("FAIL hr_stall got %0d exp 4", stall_count); else pass_cnt++;
    PC_En = 1'b1; IFID_ctrl = 1'b1; imem_rdata = 32'h4444_4444; tick();
    total_cnt++; if (IF_ID_instr !== 32'h4444_4444) $display("FAIL hr_instr got %h exp 44444444", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0040_0304) $display("FAIL hr_pc4 got %h exp 00400304", IF_ID_pc4); else pass_cnt++;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; tick();
    branch_taken = 1'b0;
    total_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); else pass_cnt++;
    imem_rdata = 32'h5555_5555; tick();
    total_cnt++; if (IF_ID_pc4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_pc got %h exp 0", imem_addr); else pass_cnt++;
  endtask

  task automatic test_saturate_reset();
    PC_En = 1'b0; IFID_ctrl = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    total_cnt++; if (stall_count !== 16'hFFFF) $display("FAIL sat_count got %h exp ffff", stall_count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (stall_count !== 16'h0) $display("FAIL arst_stall got %h exp 0", stall_count); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL arst_req got %h exp 0", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0040_0000) $display("FAIL arst_addr got %h exp 00400000", imem_addr); else pass_cnt++;
    total_cnt++; if (IF_ID_instr !== 32'h0) $display("FAIL arst_instr got %h exp 0", IF_ID_instr); else pass_cnt++;
    total_cnt++; if (IF_ID_pc4 !== 32'h0) $display("FAIL arst_pc4 got %h exp 0", IF_ID_pc4); else pass_cnt++;
    total_cnt++; if (IF_ID_valid !== 1'b0) $display("FAIL arst_valid got %h exp 0", IF_ID_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_branch();
    test_kill();
    test_hold_redirect();
    test_wrap();
    test_saturate_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. Holds the PC and fetches from instruction memory over a req/ready handshake. Applies branch/jump redirects and presents the registered instruction, PC+4 and a valid bit to ID. Its PC and IF/ID updates are gated by the load-use hazard unit's `PC_En` and `IFID_ctrl`, and its `IF_ID_rs`/`IF_ID_rt` outputs feed that unit.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction/address width
- `RESET_PC`, 32'h0040_0000, PC value after reset
- `CNT_WIDTH`, 16, stall counter width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PC_En`  in  1  from hazard unit; 0 = stall PC
- `IFID_ctrl`  in  1  from hazard unit; 0 = hold IF/ID register
- `branch_taken`  in  1  qualified taken branch resolved in ID
- `branch_target`  in  DATA_WIDTH  branch destination
- `jump_taken`  in  1  qualified jump in ID
- `jump_target`  in  DATA_WIDTH  jump destination
- `imem_req`  out  1  fetch request
- `imem_addr`  out  DATA_WIDTH  fetch address (= PC)
- `imem_ready`  in  1  `imem_rdata` valid this cycle; completes request
- `imem_rdata`  in  DATA_WIDTH  fetched instruction
- `IF_ID_instr`  out  DATA_WIDTH  registered instruction
- `IF_ID_pc4`  out  DATA_WIDTH  registered PC+4 of that instruction
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble
- `IF_ID_rs`  out  5  `IF_ID_instr[25:21]`
- `IF_ID_rt`  out  5  `IF_ID_instr[20:16]`
- `stall_count`  out  CNT_WIDTH  cycles with `PC_En`=0, saturating

## Operation
- Definitions:
  - advance = `PC_En` & `IFID_ctrl`
  - redirect = `branch_taken` | `jump_taken`
  - target = `branch_target` if `branch_taken`, else `jump_target`; branch has priority.
- Handshake:
  - `imem_addr` = pc_q and stays stable while `imem_req`=1 until `imem_ready`.
  - `imem_req`=1 in FETCH and KILL, 0 in HOLD.
  - Exactly one response per request.
- Flush: every redirect writes IF/ID = {instr 0, pc4 0, valid 0} regardless of `IFID_ctrl`; redirect overrides stall.
- Bubble: any cycle with `IFID_ctrl`=1 and no instruction delivered writes valid=0, instr=0.
- FETCH:
  - ready & redirect: discard data, pc_q<=target, flush, stay FETCH.
  - ready & advance: IF/ID<={rdata, pc_q+4, 1}, pc_q<=pc_q+4.
  - ready & !advance: buf<=rdata, go HOLD, IF/ID unchanged.
  - !ready & redirect: redir_q<=target, flush, go KILL.
  - !ready otherwise: bubble if `IFID_ctrl`, else hold.
- KILL (outstanding fetch to wrong path):
  - keep requesting old pc_q.
  - new redirect overwrites redir_q.
  - on ready: discard data, pc_q<=redir_q (or the new target if a redirect arrives the same cycle), go FETCH.
  - IF/ID gets a bubble when `IFID_ctrl`=1.
- HOLD:
  - redirect: drop buf, pc_q<=target, flush, go FETCH.
  - advance: IF/ID<={buf, pc_q+4, 1}, pc_q<=pc_q+4, go FETCH.
  - else stay.
- Arithmetic: PC+4 modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0. No alignment checking.
- `stall_count` increments when `PC_En`=0 and saturates at all-ones.

## Timing
- Reset (async, immediate):
  - pc_q=`RESET_PC`, state FETCH.
  - IF_ID_instr=0, IF_ID_pc4=0, IF_ID_valid=0, stall_count=0, buf=0, redir_q=0.
  - `imem_req`=0 while `rst_n`=0, 1 in the first cycle after deassertion.
- Throughput: with zero-wait memory (ready in the same cycle as req), one instruction per cycle.
- Latency: the IF/ID output is valid the cycle after `imem_ready`.
- Stall entry, exit and redirect each take effect at the next edge. A redirect's target is requested the cycle after the redirect, or the cycle after the pending ready when in KILL.
- Reset mid-fetch abandons the request. Memory must drop the outstanding response on reset.
- `imem_ready` while `imem_req`=0 is ignored.

## Structure
- Shared pipeline package:
  - fetch state enum {FETCH, KILL, HOLD}
  - `RESET_PC`
  - NOP constant 32'h0
  - rs/rt field bit positions
- One sub-module, `ifid_reg`: IF/ID register with write enable, flush and async reset.
- FSM, PC, buf, redir_q and counter live in the top module.

## Test plan
- Reset, zero-wait memory, no stalls -> `imem_addr` 0x00400000, 0x00400004, 0x00400008 on successive cycles; IF_ID_pc4 0x00400004 one cycle after the first ready, valid=1.
- `PC_En`=`IFID_ctrl`=0 for 2 cycles while ready with 0x8C820000 -> state HOLD, `imem_req`=0, IF/ID frozen, stall_count=2. On release IF_ID_instr=0x8C820000 and the PC advances by 4.
- `branch_taken`=1, target 0x00400100, in FETCH with ready -> IF_ID_valid=0 next cycle, `imem_addr`=0x00400100.
- 3-cycle memory, `jump_taken` target 0x00400200 in wait cycle 1 -> KILL; old data discarded; `imem_addr`=0x00400200 after the ready; bubbles in between.
- Redirect while stalled in HOLD -> buffer dropped, flush despite `IFID_ctrl`=0, fetch from target.
- `PC_En`=0 for 70000 cycles -> stall_count saturates at 0xFFFF. Assert `rst_n`=0 mid-wait -> all outputs at reset values immediately.
